// File: rtl/superscalar_fifo_if.sv
// Handshake and status bundle for superscalar_fifo.
// The err signal exists only when SS_FIFO_ERR_EN is defined.
interface superscalar_fifo_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int IN_W  = 3,
    parameter int OUT_W = 3
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(IN_W + 1);
    localparam int RW = $clog2(OUT_W + 1);

    // Producer side
    logic [WW-1:0]              wr_count;
    logic [IN_W-1:0][WIDTH-1:0] wr_data;
    logic [WW-1:0]              wr_accept;

    // Consumer side
    logic [RW-1:0]               rd_count;
    logic [OUT_W-1:0][WIDTH-1:0] rd_data;
    logic [OUT_W-1:0]            rd_valid;
    logic [RW-1:0]               rd_taken;

    // Status
    logic [CW-1:0] count;
    logic [CW-1:0] free_slots;
    logic          almost_full;
    logic          full;
    logic          empty;
`ifdef SS_FIFO_ERR_EN
    logic          err;
`endif

    // Producer/consumer view
    modport master (
`ifdef SS_FIFO_ERR_EN
        input  err,
`endif
        output wr_count, wr_data, rd_count,
        input  wr_accept, rd_data, rd_valid, rd_taken,
        input  count, free_slots, almost_full, full, empty
    );

    // FIFO view
    modport slave (
`ifdef SS_FIFO_ERR_EN
        output err,
`endif
        input  wr_count, wr_data, rd_count,
        output wr_accept, rd_data, rd_valid, rd_taken,
        output count, free_slots, almost_full, full, empty
    );
endinterface

// File: rtl/superscalar_fifo.sv
// superscalar_fifo: N-in / M-out synchronous FIFO for packet buffering
// between superscalar pipeline stages. Occupancy lives in a single count
// register that alone decides full/empty; pointers wrap by compare-and-
// subtract so DEPTH need not be a power of two.
// Optional feature: define SS_FIFO_ERR_EN to add a sticky err flag that
// records any overflow or underflow request.
module superscalar_fifo #(
    parameter int DEPTH       = 16,
    parameter int WIDTH       = 32,
    parameter int IN_W        = 3,
    parameter int OUT_W       = 3,
    parameter int ALERT_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    superscalar_fifo_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = $clog2(IN_W + 1);
    localparam int RW = $clog2(OUT_W + 1);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [CW-1:0]    free_w;
    logic [WW-1:0]    wr_accept_w;
    logic [RW-1:0]    rd_taken_w;

`ifdef SS_FIFO_ERR_EN
    logic             err_q, err_d;
`endif

    // Pointer advance with wrap; offset is always < DEPTH so one subtract suffices.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= DEPTH) sum = sum - DEPTH;
        return PW'(sum);
    endfunction

    // Grant sizes from registered occupancy only; reads never create same-cycle write credit.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later statements see earlier results;
        // clocked blocks use '<=' so every flop samples pre-edge values.
        free_w      = CW'(DEPTH) - count_q;
        wr_accept_w = (CW'(bus.wr_count) > free_w)  ? WW'(free_w)  : bus.wr_count;
        rd_taken_w  = (CW'(bus.rd_count) > count_q) ? RW'(count_q) : bus.rd_count;
    end

    // Next-state: write accepted slots, advance pointers, update occupancy.
    always_comb begin
        // NOTE: every target gets a full default before any conditional update,
        // so no path leaves a value unassigned and no latch is inferred.
        mem_d = mem_q;
        for (int i = 0; i < IN_W; i++) begin
            if (i < int'(wr_accept_w)) mem_d[wrap_add(tail_q, i)] = bus.wr_data[i];
        end
        tail_d  = wrap_add(tail_q, int'(wr_accept_w));
        head_d  = wrap_add(head_q, int'(rd_taken_w));
        // count + wr_accept never exceeds DEPTH, so this CW-bit sum cannot overflow.
        count_d = count_q + CW'(wr_accept_w) - CW'(rd_taken_w);
    end

`ifdef SS_FIFO_ERR_EN
    // Sticky error: any request beyond what the FIFO can honour this cycle.
    always_comb begin
        err_d = err_q
              | (CW'(bus.wr_count) > free_w)
              | (CW'(bus.rd_count) > count_q);
    end
`endif

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: the storage array is reset too, because stale (ignored) read
            // slots must still show zero immediately after reset.
            mem_q   <= '{default: '0};
`ifdef SS_FIFO_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
`ifdef SS_FIFO_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Read window: slot i shows entry head+i; valid only below the registered count.
    always_comb begin
        bus.rd_data  = '0;
        bus.rd_valid = '0;
        for (int i = 0; i < OUT_W; i++) begin
            bus.rd_data[i]  = mem_q[wrap_add(head_q, i)];
            bus.rd_valid[i] = (i < int'(count_q));
        end
    end

    assign bus.wr_accept   = wr_accept_w;
    assign bus.rd_taken    = rd_taken_w;
    assign bus.count       = count_q;
    assign bus.free_slots  = free_w;
    assign bus.almost_full = (free_w <= CW'(ALERT_DEPTH));
    assign bus.full        = (count_q == CW'(DEPTH));
    assign bus.empty       = (count_q == '0);
`ifdef SS_FIFO_ERR_EN
    assign bus.err         = err_q;
`endif

endmodule

// File: tb/tb_superscalar_fifo.sv
// Self-checking bench for superscalar_fifo: a vector table, hand-written
// corner sequences and randomized traffic, all compared against a queue model.
module tb_superscalar_fifo;
    localparam int DEPTH       = 16;
    localparam int WIDTH       = 32;
    localparam int IN_W        = 3;
    localparam int OUT_W       = 3;
    localparam int ALERT_DEPTH = 3;
    localparam int WW          = $clog2(IN_W + 1);
    localparam int RW          = $clog2(OUT_W + 1);

    typedef logic [IN_W-1:0][WIDTH-1:0] pkt_t;

    typedef struct {
        int wc;
        int rc;
        int acc;
        int tak;
        int cnt;
        bit af;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;

    // Reference model: plain FIFO queue of stored entries plus a sticky error bit.
    logic [WIDTH-1:0] model_q[$];
    bit               err_m = 1'b0;

    superscalar_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    superscalar_fifo #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .IN_W(IN_W), .OUT_W(OUT_W), .ALERT_DEPTH(ALERT_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare every registered output against the model.
    task automatic check_state();
        int n;
        logic [OUT_W-1:0] ev;
        n = model_q.size();
        check("count", bus.count, n);
        check("free_slots", bus.free_slots, DEPTH - n);
        check("full", bus.full, n == DEPTH);
        check("empty", bus.empty, n == 0);
        check("almost_full", bus.almost_full, (DEPTH - n) <= ALERT_DEPTH);
        for (int i = 0; i < OUT_W; i++) ev[i] = (i < n);
        check("rd_valid", bus.rd_valid, ev);
        for (int i = 0; i < OUT_W; i++) begin
            if (i < n) check("rd_data", bus.rd_data[i], model_q[i]);
        end
`ifdef SS_FIFO_ERR_EN
        check("err", bus.err, err_m);
`endif
    endtask

    // One clock of traffic, entered and left at a falling edge.
    task automatic cyc(input int wc, input int rc, input pkt_t d, output int acc, output int tak);
        int n, ea, et;
        bus.wr_count = WW'(wc);
        bus.rd_count = RW'(rc);
        bus.wr_data  = d;
        n  = model_q.size();
        ea = (wc < DEPTH - n) ? wc : DEPTH - n;
        et = (rc < n) ? rc : n;
        #1;
        acc = int'(bus.wr_accept);
        tak = int'(bus.rd_taken);
        check("wr_accept", acc, ea);
        check("rd_taken", tak, et);
        if (wc > DEPTH - n || rc > n) err_m = 1'b1;
        @(posedge clk);
        repeat (et) void'(model_q.pop_front());
        for (int i = 0; i < ea; i++) model_q.push_back(d[i]);
        @(negedge clk);
        bus.wr_count = '0;
        bus.rd_count = '0;
        check_state();
    endtask

    vec_t vecs[10];
    pkt_t pkt;
    int   acc, tak;

    initial begin
        bus.wr_count = '0;
        bus.rd_count = '0;
        bus.wr_data  = '0;

        // Burst fill to full, traffic at full, and both sides of the alert threshold.
        vecs[0] = '{3, 0, 3, 0,  3, 1'b0};
        vecs[1] = '{3, 0, 3, 0,  6, 1'b0};
        vecs[2] = '{3, 0, 3, 0,  9, 1'b0};
        vecs[3] = '{3, 0, 3, 0, 12, 1'b0};
        vecs[4] = '{3, 0, 3, 0, 15, 1'b1};
        vecs[5] = '{3, 0, 1, 0, 16, 1'b1};
        vecs[6] = '{2, 3, 0, 3, 13, 1'b1};
        vecs[7] = '{0, 3, 0, 3, 10, 1'b0};
        vecs[8] = '{3, 0, 3, 0, 13, 1'b1};
        vecs[9] = '{0, 1, 0, 1, 12, 1'b0};

        // Reset state, with rd_count high to show rd_taken is clipped to zero.
        #1 rst_n = 1'b0;
        bus.rd_count = RW'(3);
        #2;
        check("rst empty", bus.empty, 1'b1);
        check("rst full", bus.full, 1'b0);
        check("rst almost_full", bus.almost_full, 1'b0);
        check("rst free_slots", bus.free_slots, DEPTH);
        check("rst count", bus.count, 0);
        check("rst rd_valid", bus.rd_valid, 0);
        check("rst rd_data", bus.rd_data, 0);
        check("rst wr_accept", bus.wr_accept, 0);
        check("rst rd_taken", bus.rd_taken, 0);
`ifdef SS_FIFO_ERR_EN
        check("rst err", bus.err, 1'b0);
`endif
        bus.rd_count = '0;
        @(negedge clk);
        rst_n = 1'b1;
        check_state();

        // Table-driven vectors.
        for (int v = 0; v < 10; v++) begin
            for (int j = 0; j < IN_W; j++) pkt[j] = 32'h1000 + 32'(v * 16 + j);
            cyc(vecs[v].wc, vecs[v].rc, pkt, acc, tak);
            check($sformatf("vec%0d accept", v), acc, vecs[v].acc);
            check($sformatf("vec%0d taken", v), tak, vecs[v].tak);
            check($sformatf("vec%0d count", v), bus.count, vecs[v].cnt);
            check($sformatf("vec%0d almost_full", v), bus.almost_full, vecs[v].af);
        end
        repeat (4) cyc(0, 3, '0, acc, tak);
        check("drain empty", bus.empty, 1'b1);

        // Asynchronous reset between edges at count 7.
        for (int j = 0; j < IN_W; j++) pkt[j] = 32'hBEEF0000 + 32'(j);
        cyc(3, 0, pkt, acc, tak);
        cyc(3, 0, pkt, acc, tak);
        cyc(1, 0, pkt, acc, tak);
        check("pre-reset count", bus.count, 7);
        #2 rst_n = 1'b0;
        #1;
        check("async count", bus.count, 0);
        check("async empty", bus.empty, 1'b1);
        check("async rd_valid", bus.rd_valid, 0);
        check("async rd_data", bus.rd_data, 0);
        model_q.delete();
        err_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // First post-reset write lands at the head (mem[0]); other slots still cleared.
        pkt = '0;
        pkt[0] = 32'h1234;
        cyc(1, 0, pkt, acc, tak);
        check("post-reset slot0", bus.rd_data[0], 32'h1234);
        check("post-reset slot1", bus.rd_data[1], 0);
        check("post-reset slot2", bus.rd_data[2], 0);

        // Underflow request: rd_count 2 with one entry.
        cyc(0, 2, '0, acc, tak);
        check("underflow taken", tak, 1);
`ifdef SS_FIFO_ERR_EN
        check("err set", bus.err, 1'b1);
        cyc(0, 0, '0, acc, tak);
        check("err held", bus.err, 1'b1);
`endif

        // Move head to 14 with the FIFO empty, then load five entries across the wrap.
        for (int k = 0; k < 4; k++) cyc(3, 0, pkt, acc, tak);
        cyc(1, 0, pkt, acc, tak);
        for (int k = 0; k < 4; k++) cyc(0, 3, '0, acc, tak);
        cyc(0, 1, '0, acc, tak);
        check("wrap pre empty", bus.empty, 1'b1);
        for (int j = 0; j < IN_W; j++) pkt[j] = 32'hC0DE0000 + 32'(j);
        cyc(3, 0, pkt, acc, tak);
        for (int j = 0; j < IN_W; j++) pkt[j] = 32'hC0DE0003 + 32'(j);
        cyc(2, 0, pkt, acc, tak);
        check("wrap count", bus.count, 5);
        check("wrap slot0", bus.rd_data[0], 32'hC0DE0000);
        check("wrap slot1", bus.rd_data[1], 32'hC0DE0001);
        check("wrap slot2", bus.rd_data[2], 32'hC0DE0002);
        cyc(0, 3, '0, acc, tak);
        check("wrap slot0 b", bus.rd_data[0], 32'hC0DE0003);
        check("wrap slot1 b", bus.rd_data[1], 32'hC0DE0004);
        cyc(0, 3, '0, acc, tak);
        check("wrap second taken", tak, 2);
        check("wrap empty", bus.empty, 1'b1);

        // Simultaneous read and write at empty: no bypass.
        pkt = '0;
        pkt[0] = 32'hA5;
        cyc(1, 1, pkt, acc, tak);
        check("empty rw taken", tak, 0);
        check("empty rw valid", bus.rd_valid, 3'b001);
        check("empty rw data", bus.rd_data[0], 32'hA5);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            for (int j = 0; j < IN_W; j++) pkt[j] = $urandom;
            cyc(int'($urandom_range(0, IN_W)), int'($urandom_range(0, OUT_W)), pkt, acc, tak);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
